// File: rtl/lab_pkg.sv
// Shared definitions for the lab-board key input path: FSM state encoding
// and debounce timing constants.
package lab_pkg;

   // Key-encoder FSM: no debounced key down, or at least one key held.
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HELD = 1'b1
   } kpe_state_e;

   // Board debounce window (about 2.5 ms at 100 MHz) and the short window
   // used to keep simulations fast.
   localparam int DB_CYCLES_DEF = 250000;
   localparam int DB_CYCLES_SIM = 4;

   // Default debounce counter width; must hold DB_CYCLES_DEF-1.
   localparam int CNT_W_DEF     = 18;

endpackage : lab_pkg

// File: rtl/debounce_bit.sv
// One key line: 2-flop synchroniser followed by a counter that accepts a new
// level only after it has differed from the stable level for DB_CYCLES
// consecutive clocks. Any return to the stable level restarts the count.
module debounce_bit
   import lab_pkg::*;
#(
   parameter int DB_CYCLES = DB_CYCLES_DEF,
   parameter int CNT_W     = CNT_W_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic in_n,
   output logic stable_n
);

   logic             sync0_q, sync0_d;
   logic             sync1_q, sync1_d;
   logic             stable_q, stable_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Next-state for the synchroniser, debounce counter and accepted level.
   always_comb begin
      sync0_d  = in_n;
      sync1_d  = sync0_q;
      stable_d = stable_q;
      cnt_d    = cnt_q;
      if (sync1_q == stable_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
         stable_d = sync1_q;
         cnt_d    = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // State registers; reset treats the line as released (high).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync0_q  <= 1'b1;
         sync1_q  <= 1'b1;
         stable_q <= 1'b1;
         cnt_q    <= '0;
      end else begin
         sync0_q  <= sync0_d;
         sync1_q  <= sync1_d;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
      end
   end

   assign stable_n = stable_q;

endmodule : debounce_bit

// File: rtl/key_priority_encoder.sv
// Registered 8-to-3 priority encoder for active-low key lines. Each line is
// synchronised and debounced on its own; the debounced vector is encoded
// (highest index wins) and a small FSM turns changes of that encoding into
// press / release strobes. All outputs come straight from flops.
module key_priority_encoder
   import lab_pkg::*;
#(
   parameter int N         = 8,
   parameter int CODE_W    = 3,
   parameter int DB_CYCLES = DB_CYCLES_DEF,
   parameter int CNT_W     = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N-1:0]      in_n,
   output logic [CODE_W-1:0] code,
   output logic              valid,
   output logic              press_stb,
   output logic              rel_stb
);

   logic [N-1:0]      stable_n;
   logic [N-1:0]      act;
   logic              any_act;
   logic [CODE_W-1:0] idx;

   kpe_state_e        state_q, state_d;
   logic [CODE_W-1:0] code_q, code_d;
   logic              valid_q, valid_d;
   logic              press_stb_q, press_stb_d;
   logic              rel_stb_q, rel_stb_d;

   for (genvar g = 0; g < N; g++) begin : g_line
      debounce_bit #(
         .DB_CYCLES (DB_CYCLES),
         .CNT_W     (CNT_W)
      ) u_db (
         .clk      (clk),
         .rst_n    (rst_n),
         .in_n     (in_n[g]),
         .stable_n (stable_n[g])
      );
   end

   // Priority encode the debounced pressed set; the ascending scan lets the
   // highest pressed index overwrite lower ones.
   always_comb begin
      act     = ~stable_n;
      any_act = |act;
      idx     = '0;
      for (int i = 0; i < N; i++) begin
         if (act[i]) idx = CODE_W'(i);
      end
   end

   // FSM next state and registered outputs; strobes default low so each
   // event lasts one cycle, and the branches keep press and release exclusive.
   always_comb begin
      state_d     = state_q;
      code_d      = code_q;
      valid_d     = valid_q;
      press_stb_d = 1'b0;
      rel_stb_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (any_act) begin
               state_d     = ST_HELD;
               code_d      = idx;
               valid_d     = 1'b1;
               press_stb_d = 1'b1;
            end
         end
         ST_HELD: begin
            if (!any_act) begin
               state_d   = ST_IDLE;
               valid_d   = 1'b0;
               rel_stb_d = 1'b1;
            end else if (idx != code_q) begin
               code_d      = idx;
               press_stb_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
         end
      endcase
   end

   // FSM state and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         code_q      <= '0;
         valid_q     <= 1'b0;
         press_stb_q <= 1'b0;
         rel_stb_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         code_q      <= code_d;
         valid_q     <= valid_d;
         press_stb_q <= press_stb_d;
         rel_stb_q   <= rel_stb_d;
      end
   end

   assign code      = code_q;
   assign valid     = valid_q;
   assign press_stb = press_stb_q;
   assign rel_stb   = rel_stb_q;

endmodule : key_priority_encoder

// File: tb/tb_key_priority_encoder.sv
// Bench for key_priority_encoder with the short simulation debounce window.
// A reference model, stepped on every rising edge, is compared with the DUT
// on every falling edge; scenario tasks add directed expectations on top.
module tb_key_priority_encoder;
   import lab_pkg::*;

   localparam int DB = DB_CYCLES_SIM;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] in_n  = 8'hFF;
   logic [2:0] code;
   logic       valid;
   logic       press_stb;
   logic       rel_stb;

   int n_cmp  = 0;
   int n_fail = 0;

   key_priority_encoder #(
      .N         (8),
      .CODE_W    (3),
      .DB_CYCLES (DB),
      .CNT_W     (18)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_n      (in_n),
      .code      (code),
      .valid     (valid),
      .press_stb (press_stb),
      .rel_stb   (rel_stb)
   );

   // Clock generation.
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // A line's accepted level flips once the synchronised input (two clocks
   // late) has disagreed with it on each of the last DB sampling edges.
   // Outputs react to the accepted vector as it stood before each edge.
   logic [7:0] m_stable = 8'hFF;
   logic [7:0] hist[$];
   logic [2:0] m_code   = 3'd0;
   logic       m_valid  = 1'b0;
   logic       m_press  = 1'b0;
   logic       m_rel    = 1'b0;

   initial begin
      forever begin : model_step
         logic [7:0] pressed;
         logic [2:0] top;
         logic       flip;
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_stable = 8'hFF;
            hist.delete();
            for (int k = 0; k < 6; k++) hist.push_back(8'hFF);
            m_code  = 3'd0;
            m_valid = 1'b0;
            m_press = 1'b0;
            m_rel   = 1'b0;
         end else begin
            pressed = ~m_stable;
            top     = 3'd0;
            for (int i = 0; i < 8; i++) if (pressed[i]) top = 3'(i);
            m_press = 1'b0;
            m_rel   = 1'b0;
            if (!m_valid && pressed != 8'h00) begin
               m_valid = 1'b1;
               m_code  = top;
               m_press = 1'b1;
            end else if (m_valid && pressed == 8'h00) begin
               m_valid = 1'b0;
               m_rel   = 1'b1;
            end else if (m_valid && top != m_code) begin
               m_code  = top;
               m_press = 1'b1;
            end
            // hist[size-k] holds the input sampled k edges ago.
            for (int b = 0; b < 8; b++) begin
               flip = 1'b1;
               for (int k = 2; k < 2 + DB; k++) begin
                  if (hist[hist.size() - k][b] == m_stable[b]) flip = 1'b0;
               end
               if (flip) m_stable[b] = ~m_stable[b];
            end
            hist.push_back(in_n);
            if (hist.size() > 10) void'(hist.pop_front());
         end
      end
   end

   // ---------------- monitor ----------------
   int         n_press = 0;
   int         n_rel   = 0;
   int         n_both  = 0;
   int         n_diff  = 0;
   logic [2:0] press_codes[$];
   logic [5:0] diff_dut = '0;
   logic [5:0] diff_exp = '0;
   longint     diff_t   = 0;

   initial begin
      forever begin
         @(negedge clk);
         if (press_stb === 1'b1) begin
            n_press++;
            press_codes.push_back(code);
         end
         if (rel_stb === 1'b1) n_rel++;
         if (press_stb === 1'b1 && rel_stb === 1'b1) n_both++;
         if ({code, valid, press_stb, rel_stb} !== {m_code, m_valid, m_press, m_rel}) begin
            n_diff++;
            diff_dut = {code, valid, press_stb, rel_stb};
            diff_exp = {m_code, m_valid, m_press, m_rel};
            diff_t   = $time;
         end
      end
   end

   // ---------------- driver helpers ----------------
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic go_idle();
      in_n = 8'hFF;
      repeat (12) tick();
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      int d0, p0;
      in_n  = 8'hFE;
      rst_n = 1'b0;
      repeat (3) tick();
      n_cmp++;
      if ({code, valid, press_stb, rel_stb} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %b want 000000", {code, valid, press_stb, rel_stb});
      end
      d0 = n_diff;
      p0 = n_press;
      rst_n = 1'b1;
      repeat (DB + 2) tick();
      n_cmp++;
      if (n_press - p0 !== 0 || valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_early_press: presses %0d valid %b want 0 0", n_press - p0, valid);
      end
      tick();
      n_cmp++;
      if ({code, valid, press_stb, rel_stb} !== {3'd0, 1'b1, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_first_press: got %b want 000110", {code, valid, press_stb, rel_stb});
      end
      tick();
      n_cmp++;
      if (press_stb !== 1'b0 || valid !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_press_width: press_stb %b valid %b want 0 1", press_stb, valid);
      end
      n_cmp++;
      if (n_diff - d0 !== 0) begin
         n_fail++;
         $display("FAIL reset_model: diffs %0d want 0 (t=%0d dut %b model %b)", n_diff - d0, diff_t, diff_dut, diff_exp);
      end
   endtask

   task automatic test_hold_release();
      int p0, r0;
      go_idle();
      p0 = n_press;
      r0 = n_rel;
      in_n = 8'hF7;
      repeat (20) tick();
      n_cmp++;
      if (n_press - p0 !== 1 || {code, valid} !== {3'd3, 1'b1}) begin
         n_fail++;
         $display("FAIL hold_press: presses %0d code %0d valid %b want 1 3 1", n_press - p0, code, valid);
      end
      in_n = 8'hFF;
      repeat (12) tick();
      n_cmp++;
      if (n_rel - r0 !== 1 || {code, valid} !== {3'd3, 1'b0}) begin
         n_fail++;
         $display("FAIL hold_release: releases %0d code %0d valid %b want 1 3 0", n_rel - r0, code, valid);
      end
   endtask

   task automatic test_bounce();
      int p0, r0;
      go_idle();
      p0 = n_press;
      r0 = n_rel;
      for (int i = 0; i < 3; i++) begin
         in_n = 8'hEF;
         repeat (2) tick();
         in_n = 8'hFF;
         repeat (2) tick();
      end
      n_cmp++;
      if (n_press - p0 !== 0) begin
         n_fail++;
         $display("FAIL bounce_during: presses %0d want 0", n_press - p0);
      end
      in_n = 8'hEF;
      repeat (15) tick();
      n_cmp++;
      if (n_press - p0 !== 1 || n_rel - r0 !== 0 || code !== 3'd4 || valid !== 1'b1) begin
         n_fail++;
         $display("FAIL bounce_settle: presses %0d rels %0d code %0d valid %b want 1 0 4 1",
                  n_press - p0, n_rel - r0, code, valid);
      end
   endtask

   task automatic test_index_change();
      int p0, r0, q0;
      logic [8:0] seen;
      go_idle();
      p0 = n_press;
      r0 = n_rel;
      q0 = press_codes.size();
      in_n = 8'hF7;
      repeat (12) tick();
      in_n = 8'h77;
      repeat (12) tick();
      in_n = 8'hF7;
      repeat (12) tick();
      seen = 9'h1FF;
      if (press_codes.size() - q0 == 3)
         seen = {press_codes[q0], press_codes[q0 + 1], press_codes[q0 + 2]};
      n_cmp++;
      if (n_press - p0 !== 3 || seen !== {3'd3, 3'd7, 3'd3}) begin
         n_fail++;
         $display("FAIL index_sequence: presses %0d codes %o want 3 presses codes 373", n_press - p0, seen);
      end
      in_n = 8'hF6;
      repeat (12) tick();
      n_cmp++;
      if (n_press - p0 !== 3 || n_rel - r0 !== 0 || valid !== 1'b1 || code !== 3'd3) begin
         n_fail++;
         $display("FAIL index_lower_key: presses %0d rels %0d valid %b code %0d want 3 0 1 3",
                  n_press - p0, n_rel - r0, valid, code);
      end
   endtask

   task automatic test_glitch();
      int p0, r0;
      go_idle();
      p0 = n_press;
      r0 = n_rel;
      in_n = 8'hFD;
      repeat (3) tick();
      in_n = 8'hFF;
      repeat (12) tick();
      n_cmp++;
      if (n_press - p0 !== 0 || n_rel - r0 !== 0 || valid !== 1'b0 || code !== 3'd3) begin
         n_fail++;
         $display("FAIL glitch: presses %0d rels %0d valid %b code %0d want 0 0 0 3",
                  n_press - p0, n_rel - r0, valid, code);
      end
   endtask

   task automatic test_reset_mid_press();
      int  p0;
      bit  seen_valid;
      go_idle();
      in_n = 8'hBF;
      seen_valid = 1'b0;
      for (int i = 0; i < 20 && !seen_valid; i++) begin
         tick();
         if (valid === 1'b1) seen_valid = 1'b1;
      end
      n_cmp++;
      if (!seen_valid || code !== 3'd6) begin
         n_fail++;
         $display("FAIL midreset_wait: valid seen %0d code %0d want 1 6", seen_valid, code);
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({code, valid, press_stb, rel_stb} !== 6'b0) begin
         n_fail++;
         $display("FAIL midreset_async: got %b want 000000", {code, valid, press_stb, rel_stb});
      end
      tick();
      rst_n = 1'b1;
      p0 = n_press;
      repeat (DB + 2) tick();
      n_cmp++;
      if (n_press - p0 !== 0 || valid !== 1'b0) begin
         n_fail++;
         $display("FAIL midreset_early: presses %0d valid %b want 0 0", n_press - p0, valid);
      end
      tick();
      n_cmp++;
      if ({code, valid, press_stb} !== {3'd6, 1'b1, 1'b1}) begin
         n_fail++;
         $display("FAIL midreset_repress: code %0d valid %b press_stb %b want 6 1 1", code, valid, press_stb);
      end
   endtask

   task automatic test_random();
      int d0, b0, p0;
      d0 = n_diff;
      b0 = n_both;
      p0 = n_press;
      for (int s = 0; s < 50; s++) begin
         if ($urandom_range(0, 3) == 0) in_n = 8'hFF;
         else in_n = 8'($urandom);
         repeat ($urandom_range(1, 10)) tick();
      end
      go_idle();
      n_cmp++;
      if (n_diff - d0 !== 0) begin
         n_fail++;
         $display("FAIL random_model: diffs %0d want 0 (t=%0d dut %b model %b)", n_diff - d0, diff_t, diff_dut, diff_exp);
      end
      n_cmp++;
      if (n_both - b0 !== 0 || valid !== 1'b0) begin
         n_fail++;
         $display("FAIL random_exclusive: both-strobe cycles %0d valid %b want 0 0", n_both - b0, valid);
      end
      n_cmp++;
      if (n_press - p0 < 1) begin
         n_fail++;
         $display("FAIL random_activity: presses %0d want at least 1", n_press - p0);
      end
   endtask

   // ---------------- sequence ----------------
   initial begin
      int d_all;
      test_reset();
      test_hold_release();
      test_bounce();
      test_index_change();
      test_glitch();
      test_reset_mid_press();
      test_random();
      d_all = n_diff;
      n_cmp++;
      if (d_all !== 0) begin
         n_fail++;
         $display("FAIL overall_model: diffs %0d want 0 (t=%0d dut %b model %b)", d_all, diff_t, diff_dut, diff_exp);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   // Backstop so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: simulation time limit reached, compared %0d", n_cmp);
      $fatal(1, "timeout");
   end

endmodule : tb_key_priority_encoder
